// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: byte-stream command parser in front of the 16-bit ALU and
// two-byte (LSB first) result writer into the TX FIFO.
module alu_cmd_ctrl #(
  parameter int          TIMEOUT = 16,
  parameter logic [7:0]  OP_FULL = 8'hCC,
  parameter logic [7:0]  OP_FUN  = 8'hDD
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RX_P_DATA,
  input  logic        RX_D_VLD,
  output logic [15:0] ALU_A,
  output logic [15:0] ALU_B,
  output logic [3:0]  ALU_FUN,
  output logic        ALU_EN,
  input  logic [15:0] ALU_OUT,
  input  logic        ALU_OUT_VALID,
  input  logic        FIFO_FULL,
  output logic [7:0]  WR_DATA,
  output logic        WR_INC,
  output logic        CMD_ERR,
  output logic        BUSY
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_GET_A0,
    S_GET_A1,
    S_GET_B0,
    S_GET_B1,
    S_GET_FUN,
    S_RUN,
    S_WAIT_RES,
    S_SEND_LO,
    S_SEND_HI
  } state_t;

  state_t            state_reg, state_next;
  logic [15:0]       alu_a_reg, alu_a_next;
  logic [15:0]       alu_b_reg, alu_b_next;
  logic [3:0]        alu_fun_reg, alu_fun_next;
  logic [15:0]       result_reg, result_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [7:0]        wr_data_reg, wr_data_next;
  logic              alu_en_c;
  logic              wr_inc_c;
  logic              cmd_err_c;

  // State, operand, result, timeout and last-written-byte registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg   <= S_IDLE;
      alu_a_reg   <= '0;
      alu_b_reg   <= '0;
      alu_fun_reg <= '0;
      result_reg  <= '0;
      cnt_reg     <= '0;
      wr_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      alu_a_reg   <= alu_a_next;
      alu_b_reg   <= alu_b_next;
      alu_fun_reg <= alu_fun_next;
      result_reg  <= result_next;
      cnt_reg     <= cnt_next;
      wr_data_reg <= wr_data_next;
    end
  end

  // Next-state, register updates and strobes for every state.
  always_comb begin
    state_next   = state_reg;
    alu_a_next   = alu_a_reg;
    alu_b_next   = alu_b_reg;
    alu_fun_next = alu_fun_reg;
    result_next  = result_reg;
    cnt_next     = cnt_reg;
    wr_data_next = wr_data_reg;
    alu_en_c     = 1'b0;
    wr_inc_c     = 1'b0;
    cmd_err_c    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == OP_FULL) begin
            state_next = S_GET_A0;
          end else if (RX_P_DATA == OP_FUN) begin
            state_next = S_GET_FUN;
          end else begin
            cmd_err_c = 1'b1;
          end
        end
      end

      S_GET_A0: begin
        if (RX_D_VLD) begin
          alu_a_next[7:0] = RX_P_DATA;
          state_next      = S_GET_A1;
        end
      end

      S_GET_A1: begin
        if (RX_D_VLD) begin
          alu_a_next[15:8] = RX_P_DATA;
          state_next       = S_GET_B0;
        end
      end

      S_GET_B0: begin
        if (RX_D_VLD) begin
          alu_b_next[7:0] = RX_P_DATA;
          state_next      = S_GET_B1;
        end
      end

      S_GET_B1: begin
        if (RX_D_VLD) begin
          alu_b_next[15:8] = RX_P_DATA;
          state_next       = S_GET_FUN;
        end
      end

      S_GET_FUN: begin
        if (RX_D_VLD) begin
          // Only the low nibble selects the function.
          alu_fun_next = RX_P_DATA[3:0];
          state_next   = S_RUN;
        end
      end

      S_RUN: begin
        alu_en_c   = 1'b1;
        cnt_next   = '0;
        state_next = S_WAIT_RES;
        cmd_err_c  = RX_D_VLD;
      end

      S_WAIT_RES: begin
        cmd_err_c = RX_D_VLD;
        // A valid result arriving on the terminal count still wins.
        if (ALU_OUT_VALID) begin
          result_next = ALU_OUT;
          state_next  = S_SEND_LO;
        end else if (cnt_reg == CNT_LAST) begin
          cmd_err_c  = 1'b1;
          cnt_next   = '0;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      S_SEND_LO: begin
        cmd_err_c = RX_D_VLD;
        if (!FIFO_FULL) begin
          wr_inc_c     = 1'b1;
          wr_data_next = result_reg[7:0];
          state_next   = S_SEND_HI;
        end
      end

      S_SEND_HI: begin
        cmd_err_c = RX_D_VLD;
        if (!FIFO_FULL) begin
          wr_inc_c     = 1'b1;
          wr_data_next = result_reg[15:8];
          state_next   = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign ALU_A   = alu_a_reg;
  assign ALU_B   = alu_b_reg;
  assign ALU_FUN = alu_fun_reg;
  assign ALU_EN  = alu_en_c;
  // WR_DATA shows the new byte in its write cycle and holds it afterwards.
  assign WR_DATA = wr_data_next;
  assign WR_INC  = wr_inc_c;
  assign CMD_ERR = cmd_err_c;
  assign BUSY    = (state_reg != S_IDLE);

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Testbench for alu_cmd_ctrl: ALU stub, scoreboard queues and a monitor that
// checks ALU operands and FIFO writes as the DUT presents them.
module tb_alu_cmd_ctrl;

  localparam int TIMEOUT = 16;
  localparam logic [7:0] OP_FULL = 8'hCC;
  localparam logic [7:0] OP_FUN  = 8'hDD;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RX_P_DATA = 8'h00;
  logic        RX_D_VLD = 1'b0;
  logic [15:0] ALU_A, ALU_B;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VALID;
  logic        FIFO_FULL = 1'b0;
  logic [7:0]  WR_DATA;
  logic        WR_INC, CMD_ERR, BUSY;

  alu_cmd_ctrl #(.TIMEOUT(TIMEOUT), .OP_FULL(OP_FULL), .OP_FUN(OP_FUN)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID), .FIFO_FULL(FIFO_FULL),
    .WR_DATA(WR_DATA), .WR_INC(WR_INC), .CMD_ERR(CMD_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Behavioural ALU used both by the stub and by the expected-result model.
  function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    case (f)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a * b;
      4'd3: return (b != 0) ? a / b : 16'h0000;
      4'd4: return a & b;
      4'd5: return a | b;
      4'd6: return a ^ b;
      4'd7: return ~a;
      4'd8: return a >> 1;
      4'd9: return a << 1;
      default: return 16'h0000;
    endcase
  endfunction

  // ALU stub: result valid alu_lat cycles after ALU_EN, never when hung.
  logic alu_hang = 1'b0;
  int   alu_lat = 1;
  int   alu_pend;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ALU_OUT_VALID <= 1'b0;
      ALU_OUT       <= 16'h0000;
      alu_pend      <= 0;
    end else begin
      ALU_OUT_VALID <= 1'b0;
      if (ALU_EN && !alu_hang) begin
        ALU_OUT <= alu_fn(ALU_A, ALU_B, ALU_FUN);
        if (alu_lat <= 1) ALU_OUT_VALID <= 1'b1;
        else alu_pend <= alu_lat - 1;
      end else if (alu_pend > 0) begin
        alu_pend <= alu_pend - 1;
        if (alu_pend == 1) ALU_OUT_VALID <= 1'b1;
      end
    end
  end

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  f;
  } op_t;

  op_t        exp_ops[$];
  logic [7:0] exp_bytes[$];
  int         wr_cyc_q[$];
  logic [15:0] m_a = 16'h0000, m_b = 16'h0000;
  int exp_err = 0, err_seen = 0;
  int en_cyc = 0, err_cyc = 0, last_rx = 0;
  logic [7:0] last_wr = 8'h00;
  logic fifo_rand = 1'b0;

  // Monitor: checks operands at ALU_EN and each FIFO write against the queues.
  always @(negedge CLK) begin
    if (RST) begin
      if (ALU_EN) begin
        en_cyc = cyc;
        if (exp_ops.size() == 0) chk("unexpected_alu_en", 1, 0);
        else begin
          op_t op;
          op = exp_ops.pop_front();
          chk("alu_a", ALU_A, op.a);
          chk("alu_b", ALU_B, op.b);
          chk("alu_fun", ALU_FUN, op.f);
        end
      end
      if (CMD_ERR) begin
        err_seen++;
        err_cyc = cyc;
      end
      if (WR_INC) begin
        wr_cyc_q.push_back(cyc);
        chk("wr_while_full", FIFO_FULL, 0);
        if (exp_bytes.size() == 0) chk("unexpected_wr", 1, 0);
        else chk("wr_data", WR_DATA, exp_bytes.pop_front());
        $display("write cyc=%0d data=%02h", cyc, WR_DATA);
        last_wr = WR_DATA;
      end else begin
        chk("wr_data_hold", WR_DATA, last_wr);
      end
    end else begin
      last_wr = 8'h00;
    end
  end

  // Random FIFO backpressure when enabled.
  initial begin
    forever begin
      @(posedge CLK); #1;
      if (fifo_rand) FIFO_FULL = ($urandom_range(0, 2) == 0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    last_rx   = cyc;
    @(posedge CLK); #1;
    RX_D_VLD  = 1'b0;
    repeat (gap) begin @(posedge CLK); #1; end
  endtask

  function automatic void expect_run(input logic [3:0] f);
    op_t op;
    logic [15:0] r;
    op.a = m_a; op.b = m_b; op.f = f;
    exp_ops.push_back(op);
    if (!alu_hang) begin
      r = alu_fn(m_a, m_b, f);
      exp_bytes.push_back(r[7:0]);
      exp_bytes.push_back(r[15:8]);
    end
  endfunction

  task automatic send_full(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                           input int gmax, input int lastgap);
    logic [7:0] fb;
    fb = {4'($urandom_range(0, 15)), f};
    send_byte(OP_FULL, $urandom_range(0, gmax));
    send_byte(a[7:0], $urandom_range(0, gmax));
    send_byte(a[15:8], $urandom_range(0, gmax));
    send_byte(b[7:0], $urandom_range(0, gmax));
    send_byte(b[15:8], $urandom_range(0, gmax));
    m_a = a; m_b = b;
    expect_run(f);
    send_byte(fb, lastgap);
    $display("frame FULL a=%04h b=%04h fun=%0d", a, b, f);
  endtask

  task automatic send_fun(input logic [3:0] f, input int gmax, input int lastgap);
    send_byte(OP_FUN, $urandom_range(0, gmax));
    expect_run(f);
    send_byte({4'($urandom_range(0, 15)), f}, lastgap);
    $display("frame FUN a=%04h b=%04h fun=%0d", m_a, m_b, f);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (BUSY && n < 300) begin @(posedge CLK); #1; n++; end
    chk(name, BUSY, 0);
  endtask

  initial begin
    int base, kind;
    logic [7:0] junk;

    // Reset state
    repeat (3) @(posedge CLK); #1;
    chk("rst_alu_a", ALU_A, 0); chk("rst_alu_b", ALU_B, 0);
    chk("rst_alu_fun", ALU_FUN, 0); chk("rst_alu_en", ALU_EN, 0);
    chk("rst_wr_data", WR_DATA, 0); chk("rst_wr_inc", WR_INC, 0);
    chk("rst_cmd_err", CMD_ERR, 0); chk("rst_busy", BUSY, 0);
    RST = 1'b1;
    @(posedge CLK); #1;

    // Full frame CC,0F,00,03,00,00: latency T+3 / T+4
    wr_cyc_q.delete();
    send_full(16'd15, 16'd3, 4'd0, 0, 0);
    base = last_rx;
    wait_idle("idle_full");
    chk("full_nwr", wr_cyc_q.size(), 2);
    if (wr_cyc_q.size() == 2) begin
      chk("full_lsb_cyc", wr_cyc_q[0] - base, 3);
      chk("full_msb_cyc", wr_cyc_q[1] - base, 4);
    end
    chk("full_a_hold", ALU_A, 16'd15);

    // FUN-only frame reuses A/B: 15*3
    send_fun(4'd2, 0, 0);
    wait_idle("idle_fun");
    chk("fun_b_hold", ALU_B, 16'd3);

    // Backpressure: FULL for 5 cycles entering SEND_LO
    wr_cyc_q.delete();
    FIFO_FULL = 1'b1;
    send_full(16'd7, 16'd9, 4'd2, 1, 0);
    base = last_rx;
    repeat (7) begin @(posedge CLK); #1; end
    FIFO_FULL = 1'b0;
    wait_idle("idle_bp");
    chk("bp_nwr", wr_cyc_q.size(), 2);
    if (wr_cyc_q.size() == 2) begin
      chk("bp_lsb_cyc", wr_cyc_q[0] - base, 8);
      chk("bp_msb_cyc", wr_cyc_q[1] - base, 9);
    end

    // Timeout: ALU never answers
    alu_hang = 1'b1;
    wr_cyc_q.delete();
    send_fun(4'd4, 0, 0);
    exp_err++;
    wait_idle("idle_timeout");
    chk("timeout_dist", err_cyc - en_cyc, TIMEOUT);
    chk("timeout_nwr", wr_cyc_q.size(), 0);
    chk("timeout_err", err_seen, exp_err);
    alu_hang = 1'b0;
    send_fun(4'd5, 0, 0);
    wait_idle("idle_after_timeout");

    // Bad opcode in IDLE
    send_byte(8'h55, 2);
    exp_err++;
    chk("badop_busy", BUSY, 0);
    chk("badop_err", err_seen, exp_err);

    // RX strobe during WAIT_RES, result 15-3 still sent
    alu_lat = 3;
    send_full(16'd15, 16'd3, 4'd1, 0, 1);
    send_byte(8'hAA, 0);
    exp_err++;
    wait_idle("idle_wait_rx");
    chk("wait_rx_err", err_seen, exp_err);

    // FUN=15 result is sent normally
    alu_lat = 1;
    send_fun(4'd15, 0, 0);
    wait_idle("idle_fun15");

    // Randomized frames
    fifo_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      alu_lat = $urandom_range(1, 4);
      if (kind < 8) begin
        int lg;
        lg = $urandom_range(0, 1);
        if (kind < 4) send_full(16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)), 2, lg);
        else send_fun(4'($urandom_range(0, 15)), 2, lg);
        if ($urandom_range(0, 2) == 0) begin
          send_byte(8'($urandom), 0);
          exp_err++;
        end
      end else begin
        junk = 8'($urandom);
        while (junk == OP_FULL || junk == OP_FUN) junk = 8'($urandom);
        send_byte(junk, 1);
        exp_err++;
        $display("bad opcode %02h", junk);
      end
      wait_idle("idle_rand");
    end
    fifo_rand = 1'b0;
    FIFO_FULL = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    chk("rand_err", err_seen, exp_err);

    // Async reset in the middle of SEND_LO
    FIFO_FULL = 1'b1;
    send_full(16'h1234, 16'h0101, 4'd0, 0, 0);
    repeat (3) begin @(posedge CLK); #1; end
    #2 RST = 1'b0;
    #1;
    chk("arst_alu_a", ALU_A, 0); chk("arst_alu_b", ALU_B, 0);
    chk("arst_alu_fun", ALU_FUN, 0); chk("arst_alu_en", ALU_EN, 0);
    chk("arst_wr_data", WR_DATA, 0); chk("arst_wr_inc", WR_INC, 0);
    chk("arst_cmd_err", CMD_ERR, 0); chk("arst_busy", BUSY, 0);
    exp_bytes.delete();
    m_a = 16'h0000; m_b = 16'h0000;
    @(posedge CLK); #1;
    RST = 1'b1;
    FIFO_FULL = 1'b0;
    repeat (5) begin @(posedge CLK); #1; end
    chk("post_rst_busy", BUSY, 0);
    chk("post_rst_alu_a", ALU_A, 0);
    send_fun(4'd0, 0, 0);
    wait_idle("idle_post_rst");

    repeat (3) begin @(posedge CLK); #1; end
    chk("end_bytes_left", exp_bytes.size(), 0);
    chk("end_ops_left", exp_ops.size(), 0);
    chk("end_err", err_seen, exp_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
- Command front-end and result back-end for the 16-bit ALU.
- Parses byte-wide command frames from the UART RX path, loads operands A/B and ALU_FUN, and pulses ALU_EN.
- Captures the ALU result and pushes it as two bytes, LSB first, into the TX FIFO write port.
- Sits between the UART RX/TX synchronisers and the ALU, all in the REF clock domain.

Parameters:
- TIMEOUT, 16, max cycles to wait for ALU_OUT_VALID after ALU_EN before aborting.
- OP_FULL, 8'hCC, opcode: frame carries A_lo, A_hi, B_lo, B_hi, FUN.
- OP_FUN, 8'hDD, opcode: frame carries FUN only; reuses the stored A/B.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  asynchronous active-low reset.
- RX_P_DATA  in  8  received byte.
- RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA is valid this cycle.
- ALU_A  out  16  operand A to ALU.
- ALU_B  out  16  operand B to ALU.
- ALU_FUN  out  4  function select to ALU.
- ALU_EN  out  1  one-cycle start pulse to ALU.
- ALU_OUT  in  16  ALU result.
- ALU_OUT_VALID  in  1  ALU_OUT is valid this cycle.
- FIFO_FULL  in  1  TX FIFO full.
- WR_DATA  out  8  byte to TX FIFO.
- WR_INC  out  1  one-cycle FIFO write strobe.
- CMD_ERR  out  1  one-cycle error pulse.
- BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset (RST low, async) forces all outputs and registers to 0, state to IDLE.
  - ALU_A, ALU_B, ALU_FUN, ALU_EN, WR_DATA, WR_INC, CMD_ERR, BUSY all 0.
  - Stored operands 0, timeout counter 0.
- Reset mid-frame or mid-send abandons the frame. No partial byte pair is completed.
- FSM states: IDLE, GET_A0, GET_A1, GET_B0, GET_B1, GET_FUN, RUN, WAIT_RES, SEND_LO, SEND_HI.
- IDLE: on RX_D_VLD, byte==OP_FULL -> GET_A0; byte==OP_FUN -> GET_FUN. Any other byte: pulse CMD_ERR, stay IDLE.
- Byte-collect states advance only on RX_D_VLD and hold indefinitely otherwise (no inter-byte timeout).
  - GET_A0 loads ALU_A[7:0], GET_A1 loads ALU_A[15:8], GET_B0 loads ALU_B[7:0], GET_B1 loads ALU_B[15:8].
  - GET_FUN loads ALU_FUN=RX_P_DATA[3:0]; bits [7:4] are ignored.
- Operand registers only change on their own byte strobes. ALU_A/ALU_B persist across frames, so OP_FUN reuses the last values.
- RUN: ALU_EN=1 for exactly one cycle, clear timeout counter -> WAIT_RES.
- WAIT_RES:
  - On ALU_OUT_VALID, capture ALU_OUT into result register -> SEND_LO.
  - Otherwise increment counter; when counter==TIMEOUT-1 without valid, pulse CMD_ERR -> IDLE, and nothing is written to the FIFO.
  - ALU_OUT_VALID in the same cycle as the terminal count wins (result captured, no error).
- The ALU result is registered. The nominal path is ALU_EN at cycle N, ALU_OUT_VALID at N+1, capture at N+1, first WR_INC no earlier than N+2.
- SEND_LO: when FIFO_FULL==0, WR_DATA=result[7:0], WR_INC=1 for one cycle -> SEND_HI. While FULL, hold with WR_INC=0.
- SEND_HI: same rule with result[15:8] -> IDLE.
- WR_DATA holds its last value when WR_INC=0. WR_INC is never high on two consecutive cycles unless FIFO_FULL is low for both.
- RX_D_VLD in RUN, WAIT_RES, SEND_LO or SEND_HI: the byte is dropped, CMD_ERR pulses, and state is unaffected.
- ALU_FUN=4'b1111 is still issued; the result (0) is sent normally.
- Latency, OP_FULL frame with FIFO not full: last RX strobe at cycle T -> ALU_EN at T+1 -> LSB write T+3 -> MSB write T+4.

Test Plan:
- Reset check: RST low mid-SEND_LO -> all outputs 0 immediately (async); after release, BUSY=0 and ALU_A=0.
- Full frame: CC,0F,00,03,00,00 -> ALU_A=15, ALU_B=3, FUN=0, one ALU_EN pulse; FIFO writes 0x12 then 0x00 on consecutive cycles.
- FUN-only frame: after the previous frame, send DD,02 -> ALU_EN with A/B unchanged; writes 0x2D, 0x00 (15*3=45).
- FIFO backpressure: FIFO_FULL held high 5 cycles entering SEND_LO -> no WR_INC during those cycles; LSB written on the first cycle FULL is low, MSB the next cycle.
- Timeout: ALU model never asserts ALU_OUT_VALID -> CMD_ERR pulses once, TIMEOUT cycles after ALU_EN; zero WR_INC; BUSY drops; next frame works.
- Errors: byte 0x55 in IDLE -> CMD_ERR, stays IDLE. RX strobe during WAIT_RES -> CMD_ERR, and the result is still sent correctly (e.g. FUN=1 -> 0x0C, 0x00).
